// File: rtl/bsg_tag_tx_serializer_pkg.sv
// Shared types and sizing helpers for the bsg_tag transmit serializer.
package bsg_tag_tx_serializer_pkg;

  localparam int unsigned tag_els_gp        = 16;
  localparam int unsigned tag_lg_width_gp   = 4;
  localparam int unsigned tag_reset_ones_gp = 32;
  localparam int unsigned tag_gap_gp        = 2;

  localparam int unsigned tag_lg_els_gp     = $clog2(tag_els_gp);
  localparam int unsigned tag_payload_w_gp  = (1 << tag_lg_width_gp) - 1;

  // Header = start bit + len + data_not_reset + node_id
  function automatic int unsigned tag_hdr_len(input int unsigned lg_width, input int unsigned lg_els);
    return 2 + lg_width + lg_els;
  endfunction

  function automatic int unsigned tag_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned tag_hdr_len_gp = tag_hdr_len(tag_lg_width_gp, tag_lg_els_gp);

  typedef enum logic [2:0] {
    IDLE_PRE = 3'd0,
    IDLE     = 3'd1,
    HDR      = 3'd2,
    PAY      = 3'd3,
    SWEEP    = 3'd4,
    GAP      = 3'd5
  } bsg_tag_tx_state_e;

  typedef struct packed {
    logic [tag_lg_els_gp-1:0]    node_id;
    logic                        data_not_reset;
    logic [tag_lg_width_gp-1:0]  len;
    logic [tag_payload_w_gp-1:0] payload;
  } bsg_tag_tx_cmd_s;

endpackage

// File: rtl/bsg_tag_tx_serializer_piso.sv
// Loadable LSB-first shift register plus the single down-counter that times every FSM state.
module bsg_tag_tx_piso #(
  parameter int unsigned width_p = 25,
  parameter int unsigned cnt_w_p = 6
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic               cnt_load_i,
  input  logic [width_p-1:0] data_i,
  input  logic [cnt_w_p-1:0] count_i,
  output logic               bit_o,
  output logic               last_o
);

  logic [width_p-1:0] shift_q;
  logic [cnt_w_p-1:0] cnt_q;

  // Counter saturates at zero; every load must carry a non-zero count
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (load_i) shift_q <= data_i;
      else        shift_q <= {1'b0, shift_q[width_p-1:1]};

      if (load_i || cnt_load_i) begin
        assert (count_i != '0);
        cnt_q <= count_i;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - cnt_w_p'(1);
      end
    end
  end

  assign bit_o  = shift_q[0];
  assign last_o = (cnt_q == cnt_w_p'(1));

endmodule

// File: rtl/bsg_tag_tx_serializer.sv
// bsg_tag transmitter: serializes tag packets and master reset sweeps onto tag_data_o/tag_en_o.
module bsg_tag_tx_serializer
  import bsg_tag_tx_serializer_pkg::*;
#(
  parameter int unsigned els_p        = tag_els_gp,
  parameter int unsigned lg_width_p   = tag_lg_width_gp,
  parameter int unsigned reset_ones_p = tag_reset_ones_gp,
  parameter int unsigned gap_p        = tag_gap_gp
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic [$clog2(els_p)-1:0]      node_id_i,
  input  logic                          data_not_reset_i,
  input  logic [lg_width_p-1:0]         len_i,
  input  logic [(1<<lg_width_p)-2:0]    payload_i,
  input  logic                          sweep_v_i,
  output logic                          tag_data_o,
  output logic                          tag_en_o,
  output logic                          busy_o
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam int unsigned pay_w_lp  = (1 << lg_width_p) - 1;
  localparam int unsigned hdr_lp    = tag_hdr_len(lg_width_p, lg_els_lp);
  localparam int unsigned vec_w_lp  = hdr_lp + pay_w_lp;
  localparam int unsigned cnt_max_lp =
    tag_max(tag_max(reset_ones_p, hdr_lp), tag_max(1 << lg_width_p, gap_p));
  localparam int unsigned cnt_w_lp  = $clog2(cnt_max_lp + 1);

  bsg_tag_tx_state_e     state_q;
  logic [lg_width_p-1:0] len_q;

  logic                  piso_load;
  logic                  piso_cnt_load;
  logic [cnt_w_lp-1:0]   piso_count;
  logic [vec_w_lp-1:0]   piso_data;
  logic                  piso_bit;
  logic                  piso_last;

  // The start bit goes straight to the output at accept; the shifter holds everything after it
  assign piso_data = vec_w_lp'({payload_i, node_id_i, data_not_reset_i, len_i});

  // Counter reload on every state entry
  always_comb begin
    piso_load     = 1'b0;
    piso_cnt_load = 1'b0;
    piso_count    = '0;
    case (state_q)
      IDLE: begin
        if (sweep_v_i) begin
          piso_cnt_load = 1'b1;
          piso_count    = cnt_w_lp'(reset_ones_p);
        end else if (v_i) begin
          piso_load  = 1'b1;
          piso_count = cnt_w_lp'(hdr_lp);
        end
      end
      HDR: begin
        if (piso_last) begin
          piso_cnt_load = 1'b1;
          piso_count    = (len_q == '0) ? cnt_w_lp'(gap_p) : cnt_w_lp'(len_q);
        end
      end
      PAY, SWEEP: begin
        if (piso_last) begin
          piso_cnt_load = 1'b1;
          piso_count    = cnt_w_lp'(gap_p);
        end
      end
      default: ;
    endcase
  end

  bsg_tag_tx_piso #(
    .width_p (vec_w_lp),
    .cnt_w_p (cnt_w_lp)
  ) piso (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (piso_load),
    .cnt_load_i (piso_cnt_load),
    .data_i     (piso_data),
    .count_i    (piso_count),
    .bit_o      (piso_bit),
    .last_o     (piso_last)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE_PRE;
      len_q      <= '0;
      tag_data_o <= 1'b0;
      tag_en_o   <= 1'b0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b1;
    end else begin
      case (state_q)
        IDLE_PRE: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
        IDLE: begin
          if (sweep_v_i || v_i) begin
            state_q    <= sweep_v_i ? SWEEP : HDR;
            tag_data_o <= 1'b1;
            tag_en_o   <= 1'b1;
            ready_o    <= 1'b0;
            busy_o     <= 1'b1;
            if (!sweep_v_i) len_q <= len_i;
          end
        end
        HDR: begin
          if (piso_last && (len_q == '0)) begin
            state_q    <= GAP;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
          end else begin
            if (piso_last) state_q <= PAY;
            tag_data_o <= piso_bit;
          end
        end
        PAY: begin
          if (piso_last) begin
            state_q    <= GAP;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
          end else begin
            tag_data_o <= piso_bit;
          end
        end
        SWEEP: begin
          if (piso_last) begin
            state_q    <= GAP;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
          end
        end
        GAP: begin
          if (piso_last) begin
            state_q <= IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        default: state_q <= IDLE_PRE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_tag_tx_serializer.sv
// Scoreboard bench for bsg_tag_tx_serializer: bit-level and decoded-packet checks plus handshake timing.
module tb_bsg_tag_tx_serializer;
  import bsg_tag_tx_serializer_pkg::*;

  logic        clk;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [3:0]  node_id_i;
  logic        data_not_reset_i;
  logic [3:0]  len_i;
  logic [14:0] payload_i;
  logic        sweep_v_i;
  logic        tag_data_o;
  logic        tag_en_o;
  logic        busy_o;

  bsg_tag_tx_serializer dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n_i),
    .v_i              (v_i),
    .ready_o          (ready_o),
    .node_id_i        (node_id_i),
    .data_not_reset_i (data_not_reset_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .sweep_v_i        (sweep_v_i),
    .tag_data_o       (tag_data_o),
    .tag_en_o         (tag_en_o),
    .busy_o           (busy_o)
  );

  typedef struct packed {
    logic            sweep;
    bsg_tag_tx_cmd_s cmd;
  } exp_frame_t;

  exp_frame_t exp_frames[$];
  bit         exp_bits[$];
  int         exp_gaps[$];
  bit         frame[$];
  bit         hand_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] len_mask(input logic [3:0] l);
    return 15'((16'(1) << l) - 16'(1));
  endfunction

  // Bench tag master: decodes a completed en-run and checks it against the next expected frame
  task automatic decode_frame();
    exp_frame_t  e;
    logic [3:0]  l;
    logic [3:0]  n;
    logic [14:0] p;
    int          ones;
    if (exp_frames.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_frame: got %0d bits, want none", frame.size());
    end else begin
      e = exp_frames.pop_front();
      if (e.sweep) begin
        ones = 0;
        foreach (frame[i]) ones += int'(frame[i]);
        chk("sweep_len", frame.size(), 32);
        chk("sweep_ones", ones, 32);
      end else begin
        chk("pkt_len", frame.size(), 10 + int'(e.cmd.len));
        if (frame.size() >= 10) begin
          l = '0; n = '0; p = '0;
          for (int i = 0; i < 4; i++) l[i] = frame[1+i];
          for (int i = 0; i < 4; i++) n[i] = frame[6+i];
          for (int i = 0; i < int'(l); i++) if (10 + i < frame.size()) p[i] = frame[10+i];
          chk("pkt_start", frame[0], 1);
          chk("pkt_node", n, e.cmd.node_id);
          chk("pkt_dnr", frame[5], e.cmd.data_not_reset);
          chk("pkt_field_len", l, e.cmd.len);
          chk("pkt_payload", p, e.cmd.payload);
        end
      end
    end
    frame.delete();
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus
  initial begin
    bit prev_en;
    int zeros;
    int g;
    bit eb;
    prev_en = 1'b0;
    zeros   = 0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        exp_bits.delete();
        exp_frames.delete();
        exp_gaps.delete();
        frame.delete();
        zeros   = 0;
        prev_en = 1'b0;
      end else begin
        if (tag_en_o) begin
          if (!prev_en) begin
            if (exp_gaps.size() > 0) begin
              g = exp_gaps.pop_front();
              if (g > 0) chk("gap_cycles", zeros, g);
            end
            zeros = 0;
          end
          if (exp_bits.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_bit: got data=%0b, want no enabled bit", tag_data_o);
          end else begin
            eb = exp_bits.pop_front();
            chk("stream_bit", tag_data_o, eb);
          end
          frame.push_back(tag_data_o);
        end else begin
          if (prev_en) decode_frame();
          zeros++;
        end
        prev_en = tag_en_o;
      end
    end
  end

  task automatic push_model_bits(input logic [3:0] n, input logic d, input logic [3:0] l, input logic [14:0] p);
    exp_bits.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_bits.push_back(l[i]);
    exp_bits.push_back(d);
    for (int i = 0; i < 4; i++) exp_bits.push_back(n[i]);
    for (int i = 0; i < int'(l); i++) exp_bits.push_back(p[i]);
  endtask

  task automatic push_pkt(input logic [3:0] n, input logic d, input logic [3:0] l, input logic [14:0] p,
                          input int gap, input bit hand);
    exp_frame_t f;
    f.sweep              = 1'b0;
    f.cmd.node_id        = n;
    f.cmd.data_not_reset = d;
    f.cmd.len            = l;
    f.cmd.payload        = p & len_mask(l);
    exp_frames.push_back(f);
    exp_gaps.push_back(gap);
    if (hand) foreach (hand_q[i]) exp_bits.push_back(hand_q[i]);
    else      push_model_bits(n, d, l, p);
  endtask

  task automatic push_sweep(input int gap);
    exp_frame_t f;
    f     = '0;
    f.sweep = 1'b1;
    exp_frames.push_back(f);
    exp_gaps.push_back(gap);
    repeat (32) exp_bits.push_back(1'b1);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
  endtask

  task automatic scramble(input logic [3:0] n, input logic d, input logic [3:0] l, input logic [14:0] p);
    node_id_i        = ~n;
    data_not_reset_i = ~d;
    len_i            = ~l;
    payload_i        = ~p;
  endtask

  task automatic send_pkt(input logic [3:0] n, input logic d, input logic [3:0] l, input logic [14:0] p,
                          input int gap, input bit hand);
    wait_ready();
    node_id_i        = n;
    data_not_reset_i = d;
    len_i            = l;
    payload_i        = p;
    v_i              = 1'b1;
    push_pkt(n, d, l, p, gap, hand);
    @(posedge clk);
    #1;
    v_i = 1'b0;
    scramble(n, d, l, p);
  endtask

  task automatic do_sweep(input int gap);
    wait_ready();
    sweep_v_i = 1'b1;
    push_sweep(gap);
    @(posedge clk);
    #1;
    sweep_v_i = 1'b0;
  endtask

  initial begin
    int t;
    reset_n_i        = 1'b0;
    v_i              = 1'b0;
    sweep_v_i        = 1'b0;
    node_id_i        = '0;
    data_not_reset_i = 1'b0;
    len_i            = '0;
    payload_i        = '0;

    // Reset hold and release
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_data", tag_data_o, 0);
    chk("rst_en", tag_en_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 1);
    repeat (2) begin @(posedge clk); #1; end
    reset_n_i = 1'b1;
    #1;
    chk("pre_idle_ready", ready_o, 0);
    @(posedge clk);
    #1;
    chk("idle_ready", ready_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_en", tag_en_o, 0);
    chk("idle_data", tag_data_o, 0);

    // Sweep and its gap timing
    do_sweep(0);
    chk("sweep_busy", busy_o, 1);
    repeat (33) @(posedge clk);
    #1;
    chk("sweep_gap_ready", ready_o, 0);
    @(posedge clk);
    #1;
    chk("sweep_done_ready", ready_o, 1);

    // Hand-computed data packet: node 3, dnr 1, len 5, payload 10110 with junk above len
    hand_q = '{1,1,0,1,0,1,1,1,0,0,0,1,1,0,1};
    send_pkt(4'd3, 1'b1, 4'd5, 15'h7FF6, 3, 1'b1);

    // Hand-computed header-only reset packet: node 15, dnr 0, len 0
    hand_q = '{1,0,0,0,0,0,1,1,1,1};
    send_pkt(4'd15, 1'b0, 4'd0, 15'h7FFF, 3, 1'b1);

    // Contention: sweep wins, held packet follows
    wait_ready();
    node_id_i        = 4'd9;
    data_not_reset_i = 1'b1;
    len_i            = 4'd15;
    payload_i        = 15'h5A3C;
    v_i              = 1'b1;
    sweep_v_i        = 1'b1;
    push_sweep(3);
    push_pkt(4'd9, 1'b1, 4'd15, 15'h5A3C, 3, 1'b0);
    @(posedge clk);
    #1;
    sweep_v_i = 1'b0;
    wait_ready();
    @(posedge clk);
    #1;
    v_i = 1'b0;
    scramble(4'd9, 1'b1, 4'd15, 15'h5A3C);
    send_pkt(4'd6, 1'b1, 4'd1, 15'h0001, 3, 1'b0);

    // Mid-packet reset at payload bit 2
    send_pkt(4'd5, 1'b1, 4'd8, 15'h00C5, 3, 1'b0);
    repeat (12) @(posedge clk);
    #2;
    chk("pre_rst_en", tag_en_o, 1);
    chk("pre_rst_data", tag_data_o, 1);
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_en", tag_en_o, 0);
    chk("async_rst_data", tag_data_o, 0);
    chk("async_rst_ready", ready_o, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    do_sweep(0);
    send_pkt(4'd5, 1'b1, 4'd8, 15'h00C5, 3, 1'b0);

    // Drain
    t = 0;
    while ((exp_bits.size() > 0 || exp_frames.size() > 0) && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    chk("drain_bits", exp_bits.size(), 0);
    chk("drain_frames", exp_frames.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
